// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data memory access unit with size/alignment checks and timeout
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] inALUOutput,
    input  logic [31:0] inStoreData,
    input  logic [4:0]  inRd,
    input  logic        inRegWrite,
    input  logic        inMemtoReg,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic [2:0]  inFunct3,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWData,
    output logic [3:0]  dmemBe,
    input  logic [31:0] dmemRData,
    input  logic        dmemAck,
    output logic [31:0] writeALUOutput,
    output logic [31:0] writeDataOutput,
    output logic [4:0]  writeRd,
    output logic        writeRegWrite,
    output logic        writeMemtoReg,
    output logic        memwbEn,
    output logic        stall,
    output logic        memFault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [4:0]    rd_q, rd_d;
    logic          regwrite_q, regwrite_d;
    logic          memtoreg_q, memtoreg_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   data_q, data_d;
    logic          abort_q, abort_d;

    logic          mem_op;
    logic          legal;
    logic [3:0]    cap_be;
    logic [31:0]   cap_wdata;
    logic [31:0]   rd_shifted;
    logic [31:0]   load_ext;

    assign mem_op = valid & (inMemRead | inMemWrite);

    // Stores only exist as SB/SH/SW; the unsigned encodings are load-only.
    always_comb begin
        legal = 1'b0;
        case (inFunct3)
            3'b000: legal = 1'b1;
            3'b100: legal = ~inMemWrite;
            3'b001: legal = ~inALUOutput[0];
            3'b101: legal = ~inALUOutput[0] & ~inMemWrite;
            3'b010: legal = (inALUOutput[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        cap_be    = 4'b1111;
        cap_wdata = inStoreData;
        case (inFunct3[1:0])
            2'b00: begin
                cap_be    = 4'b0001 << inALUOutput[1:0];
                cap_wdata = {4{inStoreData[7:0]}};
            end
            2'b01: begin
                cap_be    = 4'b0011 << inALUOutput[1:0];
                cap_wdata = {2{inStoreData[15:0]}};
            end
            default: begin
                cap_be    = 4'b1111;
                cap_wdata = inStoreData;
            end
        endcase
    end

    // Alignment is already guaranteed, so shifting the word down by the byte offset puts the lane at bit 0.
    assign rd_shifted = dmemRData >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rd_shifted;
        case (f3_q)
            3'b000:  load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  load_ext = {24'b0, rd_shifted[7:0]};
            3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  load_ext = {16'b0, rd_shifted[15:0]};
            default: load_ext = rd_shifted;
        endcase
    end

    assign dmemAddr  = {addr_q[31:2], 2'b00};
    assign dmemWData = wdata_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        we_d       = we_q;
        f3_d       = f3_q;
        data_d     = data_q;
        abort_d    = abort_q;

        dmemReq         = 1'b0;
        dmemWe          = 1'b0;
        dmemBe          = 4'b0000;
        stall           = 1'b0;
        memwbEn         = 1'b1;
        memFault        = 1'b0;
        writeALUOutput  = inALUOutput;
        writeDataOutput = 32'b0;
        writeRd         = inRd;
        writeRegWrite   = inRegWrite;
        writeMemtoReg   = inMemtoReg;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    if (legal) begin
                        addr_d     = inALUOutput;
                        wdata_d    = cap_wdata;
                        be_d       = cap_be;
                        rd_d       = inRd;
                        regwrite_d = inRegWrite;
                        memtoreg_d = inMemtoReg;
                        we_d       = inMemWrite;
                        f3_d       = inFunct3;
                        data_d     = 32'b0;
                        abort_d    = 1'b0;
                        cnt_d      = '0;
                        stall      = 1'b1;
                        memwbEn    = 1'b0;
                        state_d    = S_REQ;
                    end else begin
                        memFault      = 1'b1;
                        writeRegWrite = 1'b0;
                    end
                end
            end
            S_REQ: begin
                dmemReq        = 1'b1;
                dmemWe         = we_q;
                dmemBe         = be_q;
                stall          = 1'b1;
                memwbEn        = 1'b0;
                writeALUOutput = addr_q;
                writeRd        = rd_q;
                writeRegWrite  = regwrite_q;
                writeMemtoReg  = memtoreg_q;
                // An ack arriving on the last allowed cycle still completes normally.
                if (dmemAck) begin
                    data_d  = we_q ? 32'b0 : load_ext;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    memFault = 1'b1;
                    abort_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                writeALUOutput  = addr_q;
                writeDataOutput = data_q;
                writeRd         = rd_q;
                writeRegWrite   = regwrite_q & ~abort_q;
                writeMemtoReg   = memtoreg_q;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            be_q       <= 4'b0;
            rd_q       <= 5'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            we_q       <= 1'b0;
            f3_q       <= 3'b0;
            data_q     <= 32'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            data_q     <= data_d;
            abort_q    <= abort_d;
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles in REQ waiting for dmemAck before abort.
REQ-002 clk  in  1  single clock; all state on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 valid  in  1  EX/MEM holds a live instruction.
REQ-005 inALUOutput  in  32  ALU result / effective address.
REQ-006 inStoreData  in  32  rs2 store data.
REQ-007 inRd  in  5; inRegWrite  in  1; inMemtoReg  in  1; inMemRead  in  1; inMemWrite  in  1: EX/MEM control.
REQ-008 inFunct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 dmemReq  out  1; dmemWe  out  1; dmemAddr  out  32 (bits[1:0]=0); dmemWData  out  32; dmemBe  out  4: data-memory request.
REQ-010 dmemRData  in  32; dmemAck  in  1: memory response.
REQ-011 writeALUOutput  out  32; writeDataOutput  out  32; writeRd  out  5; writeRegWrite  out  1; writeMemtoReg  out  1: MEM/WB write side.
REQ-012 memwbEn  out  1  load enable for MEM/WB register.
REQ-013 stall  out  1  freeze IF/ID/EX and EX/MEM.
REQ-014 memFault  out  1  one-cycle pulse: misaligned/illegal access or timeout.

Function
REQ-015 States IDLE, REQ, DONE; 2-bit state register; 8-bit min timeout counter.
REQ-016 IDLE, valid=0 or no mem op: write* = in* pass-through, writeDataOutput=0, memwbEn=1, stall=0.
REQ-017 IDLE, valid & (inMemRead|inMemWrite) & legal: capture address, byte-lane data, Be, Rd, RegWrite, MemtoReg, read/write, funct3; stall=1, memwbEn=0; next REQ.
REQ-018 Legal: H/HU with addr[0]=0, W with addr[1:0]=00, any B/BU; funct3 011/110/111 illegal; store with 100/101 illegal.
REQ-019 IDLE, illegal mem op: no bus request, memFault=1 same cycle, memwbEn=1, writeRegWrite=0, stall=0, stay IDLE.
REQ-020 REQ: dmemReq=1, dmemWe=captured write flag, dmemAddr={addr[31:2],2'b00}, stall=1, memwbEn=0; outputs held until ack.
REQ-021 Byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; same Be for loads.
REQ-022 Store data: B replicated x4 from bits[7:0]; H replicated x2 from bits[15:0]; W unchanged.
REQ-023 REQ & dmemAck=1: for loads extract lane by addr[1:0], sign-extend (B,H) or zero-extend (BU,HU), register into data; next DONE. Ack accepted same cycle as first dmemReq.
REQ-024 DONE: write* from captured fields, writeDataOutput=extended load data (0 for store), memwbEn=1, stall=0, dmemReq=0; next IDLE.
REQ-025 Timeout counter cleared on IDLE->REQ, increments each REQ cycle without ack; count==TIMEOUT-1 with no ack -> memFault pulse, dmemReq drops next cycle, next DONE with writeRegWrite=0.
REQ-026 Ack and timeout same cycle: ack wins, no fault.
REQ-027 dmemAck in IDLE or DONE ignored.
REQ-028 Back-to-back mem ops: each takes min 3 cycles (IDLE, REQ, DONE); no overlap of requests.

Reset
REQ-029 rst=1 immediately: state IDLE, counter 0, captured regs 0, dmemReq=0, dmemWe=0, dmemBe=0, memFault=0.
REQ-030 Reset during REQ aborts transaction without waiting for ack; no MEM/WB write of that op.
REQ-031 After rst release, first posedge behaves as IDLE per REQ-016/017.

Verification
REQ-032 LB addr 0x1003, rdata 0x80FF_FF_FF, ack 1st REQ cycle -> Be=1000, addr 0x1000, DONE writeDataOutput 0xFFFFFF80, memwbEn 1 cycle, stall 2 cycles.
REQ-033 SH addr 0x2002, data 0x0000ABCD, ack after 4 cycles -> dmemWe=1, Be=1100, WData 0xABCDABCD, stall 6 cycles, writeDataOutput 0.
REQ-034 LW addr 0x3001 -> no dmemReq, memFault=1 one cycle, writeRegWrite=0, stall 0.
REQ-035 LHU, no ack, TIMEOUT=4 -> memFault at 4th REQ cycle, DONE with writeRegWrite=0, return IDLE.
REQ-036 rst asserted mid-REQ (async, between edges) -> dmemReq 0 same instant; later ack ignored; ALU op after release passes through.
REQ-037 ALU op (no mem), valid=1 -> write* equals in* combinationally, memwbEn=1, stall=0, every cycle.
